// File: rtl/pipe_stage_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_fifo_pkg
// Description : Shared defaults for the multi-entry inter-stage buffer.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_stage_fifo_pkg;

    // Default entry count for an inter-stage buffer
    localparam int FIFO_DEPTH_DEFAULT    = 4;

    // Default width of the flattened pass-through bundle
    localparam int PAYLOAD_WIDTH_DEFAULT = 64;

    // Default flattened pass-through payload
    typedef logic [PAYLOAD_WIDTH_DEFAULT-1:0] pipe_payload_t;

endpackage : pipe_stage_fifo_pkg
`default_nettype wire

// File: rtl/pipe_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fifo_ptr
// Description : Read/write pointers and exact occupancy counter for a
//               DEPTH-entry circular buffer, with synchronous clear and a
//               sticky internal-consistency error flag.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_fifo_ptr
    import pipe_stage_fifo_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enq,
    input  logic                 deq,
    input  logic                 clear,
    output logic [PTR_WIDTH-1:0] wr_ptr,
    output logic [PTR_WIDTH-1:0] rd_ptr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow_err
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic would_overflow;

    // Occupancy past DEPTH can only come from a broken upstream gate
    assign would_overflow = (count > DEPTH_CNT) ||
                            (enq && !deq && (count == DEPTH_CNT));

    // Pointers wrap modulo DEPTH by natural overflow; clear wins over enq/deq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flag, cleared only by reset (not by flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (would_overflow) begin
            overflow_err <= 1'b1;
        end
    end

    a_count_bounded : assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_CNT);

endmodule : pipe_fifo_ptr
`default_nettype wire

// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_fifo
// Description : Multi-entry pipeline buffer between two core stages with
//               stall/flush hazard semantics (stall has priority over flush,
//               deferred flush tracked by flush_pending) and occupancy output.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_fifo
    import pipe_stage_fifo_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEFAULT,
    parameter int DEPTH         = FIFO_DEPTH_DEFAULT,
    parameter int CNT_WIDTH     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [PAYLOAD_WIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PAYLOAD_WIDTH-1:0] out_data,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     flush_pending,
    output logic [CNT_WIDTH-1:0]     count,
    output logic                     overflow_err
);

    localparam int                   PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr;
    logic [PTR_WIDTH-1:0]     rd_ptr;
    logic                     do_clear;
    logic                     enq;
    logic                     deq;

    // Ready depends only on registered state and flush, never on stall, so
    // there is no combinational path from the consumer back to the producer.
    assign in_ready  = (count < DEPTH_CNT) && !flush_pending && !flush;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    // A clear happens on the first unstalled cycle of a new or deferred flush
    assign do_clear = (flush || flush_pending) && !stall;
    assign enq      = in_valid && in_ready && !do_clear;
    assign deq      = out_valid && !stall && !do_clear;

    pipe_fifo_ptr #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .enq          (enq),
        .deq          (deq),
        .clear        (do_clear),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .overflow_err (overflow_err)
    );

    // Entry storage; reset to zero so out_data reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Deferred flush: set when a flush meets a stall, dropped on the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pending <= 1'b0;
        end else if (do_clear) begin
            flush_pending <= 1'b0;
        end else if (flush && stall) begin
            flush_pending <= 1'b1;
        end
    end

endmodule : pipe_stage_fifo
`default_nettype wire
